// File: rtl/i2s_stream_ctrl.sv
// i2s_stream_ctrl: sequences stereo frames I2Srx -> FIFO -> DSP -> holding register -> I2Stx,
// reloading the tx channel registers once per frame at the ws rising edge.
module i2s_stream_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   sclk_i,
    input  logic                   rst_n_i,
    input  logic                   ws_i,
    input  logic [WIDTH-1:0]       rxLeft_i,
    input  logic [WIDTH-1:0]       rxRight_i,
    input  logic                   rxChanged_i,
    output logic                   dspValid_o,
    output logic [WIDTH-1:0]       dspLeft_o,
    output logic [WIDTH-1:0]       dspRight_o,
    input  logic                   dspReady_i,
    input  logic                   dspValid_i,
    input  logic [WIDTH-1:0]       dspLeft_i,
    input  logic [WIDTH-1:0]       dspRight_i,
    output logic                   dspReady_o,
    output logic [WIDTH-1:0]       txLeft_o,
    output logic [WIDTH-1:0]       txRight_o,
    input  logic                   bypass_i,
    input  logic                   mute_i,
    input  logic                   clear_i,
    output logic                   overflow_o,
    output logic                   underrun_o,
    output logic [$clog2(DEPTH):0] fill_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = PW + 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    logic [WIDTH-1:0] fifo_l_q [DEPTH];
    logic [WIDTH-1:0] fifo_r_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] last_l_q, last_r_q;
    logic [WIDTH-1:0] hold_l_q, hold_r_q;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic             ws_q;
    logic             overflow_q, overflow_d;
    logic             underrun_q, underrun_d;
    state_e           state_q, state_d;

    logic rd_en, wr_en, full, ovf_set, unr_set, capture, consume, reload;

    // FIFO control: read/write qualification, overflow detection, pointer and fill update
    always_comb begin
        full     = (fill_q == FW'(DEPTH));
        rd_en    = (fill_q != '0) && dspReady_i;
        wr_en    = rxChanged_i && (!full || rd_en);
        ovf_set  = rxChanged_i && full && !rd_en;
        wr_ptr_d = wr_en ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = rd_en ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        fill_d   = fill_q;
        if (wr_en && !rd_en) begin
            fill_d = FW'(fill_q + 1'b1);
        end else if (rd_en && !wr_en) begin
            fill_d = FW'(fill_q - 1'b1);
        end
    end

    // Tx FSM next state: per-frame reload from mute, bypass, holding register or underrun
    always_comb begin
        state_d = state_q;
        tx_l_d  = tx_l_q;
        tx_r_d  = tx_r_q;
        consume = 1'b0;
        unr_set = 1'b0;
        reload  = ws_i && !ws_q;
        capture = dspValid_i && !hold_full_q;
        if (reload) begin
            if (mute_i) begin
                tx_l_d  = '0;
                tx_r_d  = '0;
                consume = hold_full_q;
            end else if (bypass_i) begin
                tx_l_d  = last_l_q;
                tx_r_d  = last_r_q;
                consume = hold_full_q;
            end else if (hold_full_q) begin
                tx_l_d  = hold_l_q;
                tx_r_d  = hold_r_q;
                consume = 1'b1;
                state_d = ST_RUN;
            end else if (state_q == ST_RUN) begin
                unr_set = 1'b1;
            end
        end
        // A new capture wins over a consume in the same cycle
        hold_full_d = capture | (hold_full_q & ~consume);
        overflow_d  = ovf_set | (overflow_q & ~clear_i);
        underrun_d  = unr_set | (underrun_q & ~clear_i);
    end

    // FIFO storage and pointers
    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_l_q[i] <= '0;
                fifo_r_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_en) begin
                fifo_l_q[wr_ptr_q] <= rxLeft_i;
                fifo_r_q[wr_ptr_q] <= rxRight_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Latest rx frame, holding register, tx channels, ws history, flags and FSM state
    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_l_q    <= '0;
            last_r_q    <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            tx_l_q      <= '0;
            tx_r_q      <= '0;
            ws_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            if (rxChanged_i) begin
                last_l_q <= rxLeft_i;
                last_r_q <= rxRight_i;
            end
            if (capture) begin
                hold_l_q <= dspLeft_i;
                hold_r_q <= dspRight_i;
            end
            hold_full_q <= hold_full_d;
            tx_l_q      <= tx_l_d;
            tx_r_q      <= tx_r_d;
            ws_q        <= ws_i;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            state_q     <= state_d;
        end
    end

    assign dspValid_o = (fill_q != '0);
    assign dspLeft_o  = fifo_l_q[rd_ptr_q];
    assign dspRight_o = fifo_r_q[rd_ptr_q];
    assign dspReady_o = ~hold_full_q;
    assign txLeft_o   = tx_l_q;
    assign txRight_o  = tx_r_q;
    assign overflow_o = overflow_q;
    assign underrun_o = underrun_q;
    assign fill_o     = fill_q;

endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// Testbench for i2s_stream_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a queue-based frame model.
module tb_i2s_stream_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    logic             sclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ws = 1'b1;
    logic [WIDTH-1:0] rx_l = '0, rx_r = '0;
    logic             rx_chg = 1'b0;
    logic             dsp_valid_o;
    logic [WIDTH-1:0] dsp_l_o, dsp_r_o;
    logic             dsp_ready_in = 1'b0;
    logic             dsp_valid_in = 1'b0;
    logic [WIDTH-1:0] dsp_l_in = '0, dsp_r_in = '0;
    logic             dsp_ready_o;
    logic [WIDTH-1:0] tx_l, tx_r;
    logic             bypass = 1'b0, mute = 1'b0, clear = 1'b0;
    logic             ovf, unr;
    logic [$clog2(DEPTH):0] fill;

    always #5 sclk = ~sclk;

    i2s_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .sclk_i      (sclk),
        .rst_n_i     (rst_n),
        .ws_i        (ws),
        .rxLeft_i    (rx_l),
        .rxRight_i   (rx_r),
        .rxChanged_i (rx_chg),
        .dspValid_o  (dsp_valid_o),
        .dspLeft_o   (dsp_l_o),
        .dspRight_o  (dsp_r_o),
        .dspReady_i  (dsp_ready_in),
        .dspValid_i  (dsp_valid_in),
        .dspLeft_i   (dsp_l_in),
        .dspRight_i  (dsp_r_in),
        .dspReady_o  (dsp_ready_o),
        .txLeft_o    (tx_l),
        .txRight_o   (tx_r),
        .bypass_i    (bypass),
        .mute_i      (mute),
        .clear_i     (clear),
        .overflow_o  (ovf),
        .underrun_o  (unr),
        .fill_o      (fill)
    );

    // Frame model: a frame is {left, right}
    typedef logic [2*WIDTH-1:0] frame_t;
    frame_t m_fifo[$];
    frame_t m_hold;
    bit     m_hold_full;
    frame_t m_last;
    frame_t m_tx;
    bit     m_primed;
    bit     m_prev_ws;
    bit     m_ovf, m_unr;
    bit     m_reloaded;

    int  phase;
    bit  loop;
    int  npass = 0;
    int  nfail = 0;
    int  ntotal = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_hold      = '0;
        m_hold_full = 1'b0;
        m_last      = '0;
        m_tx        = '0;
        m_primed    = 1'b0;
        m_prev_ws   = 1'b1;
        m_ovf       = 1'b0;
        m_unr       = 1'b0;
        m_reloaded  = 1'b0;
    endtask

    // Apply one rising edge worth of behaviour using the inputs currently driven
    task automatic model_edge();
        int     sz       = m_fifo.size();
        frame_t old_last = m_last;
        bit     had_hold = m_hold_full;
        bit     reload   = ws && !m_prev_ws;
        bit     rd       = (sz != 0) && dsp_ready_in;
        bit     ovf_set  = 1'b0;
        bit     unr_set  = 1'b0;
        bit     cons     = 1'b0;
        m_prev_ws  = ws;
        m_reloaded = reload;
        if (rd) void'(m_fifo.pop_front());
        if (rx_chg) begin
            if (sz < int'(DEPTH) || rd) m_fifo.push_back({rx_l, rx_r});
            else ovf_set = 1'b1;
            m_last = {rx_l, rx_r};
        end
        if (reload) begin
            if (mute) begin
                m_tx = '0;
                cons = had_hold;
            end else if (bypass) begin
                m_tx = old_last;
                cons = had_hold;
            end else if (had_hold) begin
                m_tx     = m_hold;
                cons     = 1'b1;
                m_primed = 1'b1;
            end else if (m_primed) begin
                unr_set = 1'b1;
            end
        end
        if (cons) m_hold_full = 1'b0;
        if (dsp_valid_in && !had_hold) begin
            m_hold      = {dsp_l_in, dsp_r_in};
            m_hold_full = 1'b1;
        end
        m_ovf = ovf_set || (m_ovf && !clear);
        m_unr = unr_set || (m_unr && !clear);
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".valid"}, 32'(dsp_valid_o), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            chk({ph, ".headL"}, 32'(dsp_l_o), 32'(m_fifo[0][2*WIDTH-1:WIDTH]));
            chk({ph, ".headR"}, 32'(dsp_r_o), 32'(m_fifo[0][WIDTH-1:0]));
        end
        chk({ph, ".fill"},  32'(fill),        32'(m_fifo.size()));
        chk({ph, ".ready"}, 32'(dsp_ready_o), 32'(!m_hold_full));
        chk({ph, ".txL"},   32'(tx_l),        32'(m_tx[2*WIDTH-1:WIDTH]));
        chk({ph, ".txR"},   32'(tx_r),        32'(m_tx[WIDTH-1:0]));
        chk({ph, ".ovf"},   32'(ovf),         32'(m_ovf));
        chk({ph, ".unr"},   32'(unr),         32'(m_unr));
    endtask

    // One clock: ws follows an 8-cycle frame; in loop mode the DSP echoes the FIFO head
    task automatic step(input string ph);
        ws = ((phase % 8) >= 4);
        phase++;
        if (loop) begin
            dsp_ready_in = 1'b1;
            dsp_valid_in = (m_fifo.size() != 0);
            if (m_fifo.size() != 0) {dsp_l_in, dsp_r_in} = m_fifo[0];
        end
        model_edge();
        @(posedge sclk);
        #1;
        check_all(ph);
    endtask

    task automatic run_to_reload(input string ph);
        for (int i = 0; i < 16; i++) begin
            step(ph);
            if (m_reloaded) break;
        end
    endtask

    task automatic rx_frame(input string ph, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        rx_l = l; rx_r = r; rx_chg = 1'b1;
        step(ph);
        rx_chg = 1'b0;
    endtask

    initial begin
        phase = 0;
        loop  = 1'b0;
        model_reset();

        // Reset values
        #12;
        check_all("reset");
        chk("reset.headL", 32'(dsp_l_o), 32'h0);
        chk("reset.headR", 32'(dsp_r_o), 32'h0);
        @(negedge sclk);
        rst_n = 1'b1;

        // Priming: no DSP output for three frames keeps tx at zero without underrun
        repeat (24) step("prime");
        chk("prime.txL", 32'(tx_l), 32'h0);
        chk("prime.unr", 32'(unr), 32'h0);

        // Loopback of one frame reaches tx at the next ws rise
        loop = 1'b1;
        dsp_ready_in = 1'b1;
        rx_frame("loop.rx", 16'hdead, 16'hbeef);
        chk("loop.valid_hi", 32'(dsp_valid_o), 32'h1);
        step("loop.rd");
        chk("loop.valid_lo", 32'(dsp_valid_o), 32'h0);
        run_to_reload("loop.wait");
        chk("loop.txL", 32'(tx_l), 32'hdead);
        chk("loop.txR", 32'(tx_r), 32'hbeef);
        chk("loop.flags", 32'({ovf, unr}), 32'h0);

        // Underrun: after tx=1234 no processed frame arrives before the next ws rise
        rx_frame("unr.rx", 16'h1234, 16'h5678);
        run_to_reload("unr.load");
        chk("unr.load_txL", 32'(tx_l), 32'h1234);
        run_to_reload("unr.miss");
        chk("unr.hold_txL", 32'(tx_l), 32'h1234);
        chk("unr.set", 32'(unr), 32'h1);
        clear = 1'b1;
        step("unr.clr");
        clear = 1'b0;
        chk("unr.cleared", 32'(unr), 32'h0);

        // Overflow: five frames into a four-deep FIFO with the DSP stalled
        loop = 1'b0;
        dsp_ready_in = 1'b0;
        dsp_valid_in = 1'b0;
        for (int i = 1; i <= 5; i++) rx_frame("ovf.wr", 16'(i), 16'(i + 16'h100));
        chk("ovf.fill", 32'(fill), 32'd4);
        chk("ovf.flag", 32'(ovf), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf.head", 32'(dsp_l_o), 32'(i));
            dsp_ready_in = 1'b1;
            step("ovf.rd");
            dsp_ready_in = 1'b0;
        end
        chk("ovf.empty", 32'(dsp_valid_o), 32'h0);
        clear = 1'b1;
        step("ovf.clr");
        clear = 1'b0;

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < 4; i++) rx_frame("full.wr", 16'(16'h11 + i), 16'(16'h21 + i));
        dsp_ready_in = 1'b1;
        rx_frame("full.rw", 16'h0077, 16'h0088);
        dsp_ready_in = 1'b0;
        chk("full.fill", 32'(fill), 32'd4);
        chk("full.ovf", 32'(ovf), 32'h0);

        // Bypass then mute
        dsp_ready_in = 1'b1;
        rx_frame("byp.rx", 16'h5555, 16'haaaa);
        bypass = 1'b1;
        run_to_reload("byp");
        chk("byp.txL", 32'(tx_l), 32'h5555);
        chk("byp.txR", 32'(tx_r), 32'haaaa);
        mute = 1'b1;
        run_to_reload("mute");
        chk("mute.tx", 32'({tx_l, tx_r}), 32'h0);
        bypass = 1'b0;
        mute = 1'b0;

        // Asynchronous reset in the middle of a frame
        dsp_ready_in = 1'b0;
        rx_frame("pre_rst", 16'h0abc, 16'h0def);
        rx_frame("pre_rst", 16'h0123, 16'h0456);
        run_to_reload("pre_rst");
        @(posedge sclk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        chk("arst.headL", 32'(dsp_l_o), 32'h0);
        chk("arst.state_prime", 32'(tx_l), 32'h0);
        @(negedge sclk);
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rx_chg       = ($urandom_range(2) == 0);
            rx_l         = 16'($urandom);
            rx_r         = 16'($urandom);
            dsp_ready_in = ($urandom_range(1) == 1);
            dsp_valid_in = ($urandom_range(2) != 0);
            dsp_l_in     = 16'($urandom);
            dsp_r_in     = 16'($urandom);
            bypass       = ($urandom_range(9) == 0);
            mute         = ($urandom_range(11) == 0);
            clear        = ($urandom_range(15) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/i2s_stream_ctrl.md
# i2s_stream_ctrl

Frame-level controller that sequences audio between I2Srx, the DSP effect chain and I2Stx. It buffers received stereo frames in a small FIFO and presents them to the DSP over a valid/ready handshake. It accepts processed frames back into a one-entry holding register and reloads the I2Stx channel registers once per frame, at a point that is safe for I2Stx. It also applies bypass/mute and flags overflow and underrun.

## Interface
Parameters:
- WIDTH, 16, sample width per channel (matches I2Stx/I2Srx)
- DEPTH, 4, input FIFO depth in stereo frames; power of two, ≥2

Ports:
- sclk_i  in  1  bit clock shared with I2Stx/I2Srx; all logic on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- ws_i  in  1  word select driven by I2Stx (0 = left, 1 = right)
- rxLeft_i, rxRight_i  in  WIDTH each  received channels from I2Srx
- rxChanged_i  in  1  one-cycle strobe from I2Srx pktI2SRxChanged_o: new frame valid
- dspValid_o  out  1  FIFO head frame available
- dspLeft_o, dspRight_o  out  WIDTH each  FIFO head frame
- dspReady_i  in  1  DSP accepts head frame
- dspValid_i  in  1  processed frame offered
- dspLeft_i, dspRight_i  in  WIDTH each  processed frame
- dspReady_o  out  1  holding register empty
- txLeft_o, txRight_o  out  WIDTH each  to I2Stx channel inputs
- bypass_i  in  1  tx takes latest rx frame directly
- mute_i  in  1  tx outputs forced to zero
- clear_i  in  1  clears sticky flags
- overflow_o  out  1  sticky: rx frame dropped
- underrun_o  out  1  sticky: tx reload with no processed frame
- fill_o  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Input FIFO: registered storage with show-ahead outputs. dspValid_o = (fill ≠ 0). dspLeft_o/dspRight_o = head entry.
- Write on rxChanged_i. Read on dspValid_o && dspReady_i. Pointers wrap modulo DEPTH.
- rxChanged_i while full with no read in the same cycle: frame dropped, FIFO unchanged, overflow_o set.
- Full with simultaneous read and write: both occur, fill unchanged, no overflow.
- Empty with simultaneous write and read: the read is not possible because dspValid_o=0; only the write occurs.
- Rx frames are written to the FIFO in all modes. Every rxChanged_i also updates a lastRx register, reset value 0.
- Holding register: dspReady_o = ~holdFull. A frame is captured on dspValid_i && dspReady_o.
- Reload event: ws_i sampled 1 this edge and 0 on the previous edge (the ws_q register resets to 1). I2Stx latches its channels at the ws falling edge, so reloading at the rising edge gives half a frame of margin.
- Tx FSM has two states, IDLE (reset) and RUN. On each reload event:
  - mute_i=1: tx ← 0. A full holding register is consumed. The state is unchanged and no underrun is flagged.
  - else bypass_i=1: tx ← lastRx. A full holding register is consumed. No underrun is flagged.
  - else holdFull: tx ← hold, holdFull cleared. IDLE→RUN.
  - else, state IDLE: tx stays 0 and no flag is raised (priming).
  - else, state RUN: tx holds its previous value and underrun_o is set.
- A capture and a consume in the same cycle: the new frame is captured and holdFull stays 1.
- clear_i clears both sticky flags. A flag-setting event in the same cycle wins.
- Reset mid-operation: FIFO is emptied, the holding register is emptied, FSM goes to IDLE, outputs go to their reset values immediately (asynchronous).

## Timing
- Reset values:
  - tx outputs 0; dspLeft_o/dspRight_o 0
  - dspValid_o 0, fill_o 0, dspReady_o 1
  - overflow_o 0, underrun_o 0; state IDLE
- rxChanged_i at edge n: fill_o increments and dspValid_o rises (if FIFO was empty) after edge n.
- Read accepted at edge n: the next head is visible after edge n.
- Capture at edge n: dspReady_o is 0 after edge n, until the reload edge that consumes the frame.
- Reload: tx outputs change at the same edge where the ws rising edge is detected. Latency from capture to tx is at most 1 frame.
- Flags update at the edge of the causing event.

## Test plan
- Reset, then drive rxChanged_i with L=dead, R=beef, DSP loops back with dspReady_i=1 → dspValid_o pulses 1 cycle. At the next ws rise, txLeft_o=dead and txRight_o=beef; FSM RUN; no flags set.
- DEPTH=4, dspReady_i=0, 5 rx frames 0001..0005 → fill_o=4 and overflow_o=1. The reads that follow return 0001..0004; frame 0005 was dropped.
- FIFO full, rxChanged_i and a read in the same cycle → fill_o stays 4 and overflow_o stays 0.
- After RUN with tx=1234, no processed frame before the next ws rise → tx stays 1234 and underrun_o=1. Then clear_i → 0.
- From reset with no DSP output across 3 frames → tx=0 and underrun_o=0 (IDLE priming).
- bypass_i=1 with last rx frame 5555/aaaa → tx=5555/aaaa at the next ws rise. Then mute_i=1 → tx=0000 at the following ws rise. Assert rst_n_i in the middle of a frame → all outputs return to their reset values immediately.
